// File: rtl/ram_bus_master.sv
// Initiator side of the Nibbler RAM bus: sequences address/weRam/csRam/salida for one
// request at a time and owns bus direction so master and RAM never drive together.
module ram_bus_master #(
    parameter int unsigned AW          = 12,
    parameter int unsigned DW          = 4,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          wr,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] address,
    output logic          weRam,
    output logic          csRam,
    inout  logic [DW-1:0] salida
);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("ram_bus_master: WAIT_CYCLES must be at least 1");
    end

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_STROBE  = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          cs_q, cs_d;
    logic          drive_q, drive_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            cs_q    <= 1'b0;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            cs_q    <= cs_d;
            drive_q <= drive_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic computes the value each registered output shows in the following cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        cs_d    = 1'b0;
        drive_d = drive_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                we_d    = 1'b0;
                drive_d = 1'b0;
                busy_d  = 1'b0;
                if (req) begin
                    state_d = S_SETUP;
                    addr_d  = addr_in;
                    we_d    = wr;
                    drive_d = wr;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cs_d    = 1'b1;
                cnt_d   = '0;
            end
            S_STROBE: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_RELEASE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = salida;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    cs_d  = 1'b1;
                end
            end
            S_RELEASE: begin
                // weRam and data stay put for one cycle after csRam falls (write hold).
                state_d = S_IDLE;
                we_d    = 1'b0;
                drive_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign address = addr_q;
    assign weRam   = we_q;
    assign csRam   = cs_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign salida  = drive_q ? wdata_q : {DW{1'bz}};

endmodule
